core_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file, PC register and the shared single-port memory bus.
- Consumes the decoder's opcode plus the ALU branch result. Drives every datapath mux select and write enable, the memory request handshake and a retired-instruction counter.

---
 rtl/core_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_core_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM for the RV32I core.
// Build option: define SEQ_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module core_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             timed_out;

  // Last waiting cycle of a bus phase; an ack on this same cycle still wins.
  assign timed_out = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    retire       = 1'b0;
    trap         = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
      end

      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        unique case (op_q)
          OP_ALU, OP_LUI, OP_JAL, OP_JALR: state_d = S_WB;
          OP_ALUI: begin
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'd1 : 2'd0;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
            cause_d = 2'd1;
`else
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        alu_b_sel    = 1'b1;
        mem_we       = (op_q == OP_STORE);
        if (mem_ack) begin
          if (op_q == OP_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
      end

      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        unique case (op_q)
          OP_ALUI: alu_b_sel = 1'b1;
          OP_LOAD: wb_sel = 2'd1;
          OP_LUI:  wb_sel = 2'd2;
          OP_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          OP_JAL: begin
            wb_sel = 2'd3;
            pc_sel = 2'd1;
          end
          OP_JALR: begin
            wb_sel = 2'd3;
            pc_sel = 2'd2;
          end
          default: ;
        endcase
      end

      S_TRAP: trap = 1'b1;

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      to_cnt_d = '0;
    else if (state_q == S_FETCH || state_q == S_MEM)
      to_cnt_d = to_cnt_q + TO_W'(1);
    else
      to_cnt_d = to_cnt_q;

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      to_cnt_q  <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      to_cnt_q  <= to_cnt_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign instret    = instret_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-instruction expectations are queued when an
// instruction is issued and compared when the sequencer retires it (or traps).
module tb_core_sequencer;

  localparam int TIMEOUT = 16;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ILL    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  logic        alu_a_sel, alu_b_sel, retire, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;

  core_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .retire(retire), .instret(instret),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       a_sel;
    logic       b_sel;
    logic       addr_sel;
    int         rf_cycles;
    int         we_cycles;
    int         req_cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fetch_delay = 0;
  int          mem_delay = 0;
  int          req_cnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] exp_instret = '0;
  int          cyc, n_ir, n_rf, n_we, n_req, n_pc, n_ret;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected retire-cycle view of one instruction, with fd/md wait cycles in FETCH/MEM.
  function automatic exp_t model(input logic [6:0] op, input int fd, input int md, input logic taken);
    exp_t e;
    e.lat = fd + 4; e.pc_sel = 2'd0; e.wb_sel = 2'd0; e.a_sel = 1'b0; e.b_sel = 1'b0;
    e.addr_sel = 1'b0; e.rf_cycles = 1; e.we_cycles = 0; e.req_cycles = fd + 1;
    case (op)
      OP_ALU: ;
      OP_ALUI:  e.b_sel = 1'b1;
      OP_LUI:   e.wb_sel = 2'd2;
      OP_AUIPC: begin e.a_sel = 1'b1; e.b_sel = 1'b1; end
      OP_JAL:   begin e.wb_sel = 2'd3; e.pc_sel = 2'd1; end
      OP_JALR:  begin e.wb_sel = 2'd3; e.pc_sel = 2'd2; end
      OP_LOAD:  begin e.lat = fd + md + 5; e.wb_sel = 2'd1; e.req_cycles += md + 1; end
      OP_STORE: begin
        e.lat = fd + md + 4; e.b_sel = 1'b1; e.addr_sel = 1'b1; e.rf_cycles = 0;
        e.we_cycles = md + 1; e.req_cycles += md + 1;
      end
      OP_BRANCH: begin e.lat = fd + 3; e.pc_sel = taken ? 2'd1 : 2'd0; e.rf_cycles = 0; end
      default:   begin e.lat = fd + 3; e.rf_cycles = 0; end
    endcase
    return e;
  endfunction

  task automatic clear_counts();
    cyc = 0; n_ir = 0; n_rf = 0; n_we = 0; n_req = 0; n_pc = 0; n_ret = 0;
  endtask

  // One clock: memory model drives ack on the falling edge, outputs sampled 1 ns later.
  task automatic step();
    @(negedge clk);
    if (force_ack) mem_ack = 1'b1;
    else mem_ack = mem_req && (req_cnt >= (mem_addr_sel ? mem_delay : fetch_delay));
    #1;
    if (mem_req && !mem_ack) req_cnt++;
    else req_cnt = 0;
    cyc++;
    n_ir += int'(ir_we); n_rf += int'(rf_we); n_we += int'(mem_we);
    n_req += int'(mem_req); n_pc += int'(pc_we); n_ret += int'(retire);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; force_ack = 1'b0; mem_ack = 1'b0;
    #1;
    check("rst_outputs", {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                          alu_a_sel, alu_b_sel, retire, trap, trap_cause}, 32'd0);
    check("rst_instret", instret, 32'd0);
    exp_instret = '0; req_cnt = 0; sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_no_req", {mem_req, trap}, 32'd0);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fd, input int md, input logic taken);
    exp_t e;
    bit   done = 1'b0;
    sb_q.push_back(model(op, fd, md, taken));
    opcode = op; branch_taken = taken; fetch_delay = fd; mem_delay = md;
    clear_counts();
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (retire) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check("pc_we", pc_we, 32'd1);
        check("pc_sel", pc_sel, e.pc_sel);
        check("wb_sel", wb_sel, e.wb_sel);
        check("alu_a_sel", alu_a_sel, e.a_sel);
        check("alu_b_sel", alu_b_sel, e.b_sel);
        check("mem_addr_sel", mem_addr_sel, e.addr_sel);
        check("latency", cyc, e.lat);
        check("instret", instret, exp_instret);
        check("ir_we_cycles", n_ir, 32'd1);
        check("rf_we_cycles", n_rf, e.rf_cycles);
        check("mem_we_cycles", n_we, e.we_cycles);
        check("mem_req_cycles", n_req, e.req_cycles);
        exp_instret++;
      end
    end
    if (!done) begin
      check("retire_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic run_trap(input logic [6:0] op, input int fd, input int md,
                          input logic [1:0] cause, input int req_cycles);
    bit seen = 1'b0;
    opcode = op; fetch_delay = fd; mem_delay = md;
    clear_counts();
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (trap) seen = 1'b1;
    end
    check("trap_entered", seen, 32'd1);
    check("trap_cause", trap_cause, cause);
    check("trap_req_cycles", n_req, req_cycles);
    check("trap_no_write", n_ret + n_pc + n_rf, 32'd0);
    check("trap_instret", instret, exp_instret);
    force_ack = 1'b1;
    clear_counts();
    repeat (5) step();
    force_ack = 1'b0;
    check("trap_sticky", trap, 32'd1);
    check("trap_cause_sticky", trap_cause, cause);
    check("trap_quiet", n_req + n_ir + n_pc + n_rf + n_ret + n_we, 32'd0);
  endtask

  initial begin
    do_reset();
    run_instr(OP_ALUI, 0, 0, 1'b0);
    run_instr(OP_LOAD, 3, 3, 1'b0);
    run_instr(OP_BRANCH, 0, 0, 1'b1);
    run_instr(OP_BRANCH, 0, 0, 1'b0);
    run_instr(OP_STORE, 0, 0, 1'b0);
    run_instr(OP_JALR, 0, 0, 1'b0);
    run_instr(OP_ALU, 1, 0, 1'b0);
    run_instr(OP_LUI, 0, 0, 1'b0);
    run_instr(OP_AUIPC, 2, 0, 1'b0);
    run_instr(OP_JAL, 0, 0, 1'b0);
    run_instr(OP_STORE, 2, 1, 1'b0);
    run_instr(OP_LOAD, 0, 0, 1'b0);
    // Ack landing on the very last allowed cycle of each bus phase must not trap.
    run_instr(OP_ALU, TIMEOUT - 1, 0, 1'b0);
    run_instr(OP_LOAD, 0, TIMEOUT - 1, 1'b0);

`ifdef SEQ_ILLEGAL_TRAP_EN
    run_trap(OP_ILL, 0, 0, 2'd1, 1);
    do_reset();
`else
    run_instr(OP_ILL, 0, 0, 1'b0);
    check("nop_trap_cause", trap_cause, 32'd0);
    run_instr(OP_ALU, 0, 0, 1'b0);
`endif

    // Abort a load mid-fetch, then confirm a clean restart.
    opcode = OP_LOAD; fetch_delay = 5; mem_delay = 0;
    repeat (3) step();
    do_reset();
    run_instr(OP_ALUI, 0, 0, 1'b0);

    run_trap(OP_ALU, 1000, 0, 2'd2, TIMEOUT);
    do_reset();
    run_instr(OP_ALUI, 0, 0, 1'b0);
    run_trap(OP_LOAD, 0, 1000, 2'd2, TIMEOUT + 1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
